// File: rtl/dma_ram_write_fifo.sv
// DMA-to-RAM write buffer: circular store of address/data words
// presented to the SDRAM controller as a show-ahead fifo.
module dma_ram_write_fifo #(
    parameter int DEPTH     = 64,
    parameter int AF_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [22:0]                wr_adr,
    input  logic [31:0]                wr_data,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       busy,
    output logic [22:0]                ram_dmafifo_adr,
    output logic [31:0]                ram_dmafifo_data,
    output logic                       ram_dmafifo_empty,
    input  logic                       ram_dmafifo_read
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF = CW'(DEPTH - AF_MARGIN);
    localparam logic [22:0] ADR_MASK = ~23'h3;

    logic [54:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty_r;
    logic          do_wr;
    logic          do_rd;
    logic [CW-1:0] count_nxt;
    logic [54:0]   head;

    // full/empty are the registered pre-pop flags, so a write into a
    // full fifo is rejected even when the same cycle pops an entry.
    assign do_wr = wr_en && !full;
    assign do_rd = ram_dmafifo_read && !empty_r;

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= {wr_adr & ADR_MASK, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            busy        <= 1'b0;
            empty_r     <= 1'b1;
            overflow    <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count       <= count_nxt;
            full        <= (count_nxt == CNT_FULL);
            almost_full <= (count_nxt >= CNT_AF);
            busy        <= (count_nxt != '0);
            empty_r     <= (count_nxt == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head is driven as zero while empty so stale entries never leak out.
    assign head              = mem[rd_ptr];
    assign ram_dmafifo_adr   = empty_r ? '0 : head[54:32];
    assign ram_dmafifo_data  = empty_r ? '0 : head[31:0];
    assign ram_dmafifo_empty = empty_r;

endmodule

// File: tb/tb_dma_ram_write_fifo.sv
// Self-checking bench for dma_ram_write_fifo against a queue model.
module tb_dma_ram_write_fifo;

    localparam int DEPTH = 64;
    localparam int AF_MARGIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [22:0] wr_adr = '0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        almost_full;
    logic [6:0]  count;
    logic        overflow;
    logic        busy;
    logic [22:0] ram_dmafifo_adr;
    logic [31:0] ram_dmafifo_data;
    logic        ram_dmafifo_empty;
    logic        ram_dmafifo_read = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [54:0] q[$];
    logic        m_ovf = 1'b0;

    dma_ram_write_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .wr_en(wr_en),
        .wr_adr(wr_adr),
        .wr_data(wr_data),
        .full(full),
        .almost_full(almost_full),
        .count(count),
        .overflow(overflow),
        .busy(busy),
        .ram_dmafifo_adr(ram_dmafifo_adr),
        .ram_dmafifo_data(ram_dmafifo_data),
        .ram_dmafifo_empty(ram_dmafifo_empty),
        .ram_dmafifo_read(ram_dmafifo_read)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count", 64'(count), 64'(n));
        check("full", 64'(full), 64'(n == DEPTH));
        check("almost_full", 64'(almost_full), 64'(n >= DEPTH - AF_MARGIN));
        check("busy", 64'(busy), 64'(n != 0));
        check("empty", 64'(ram_dmafifo_empty), 64'(n == 0));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (n != 0) begin
            check("head_adr", 64'(ram_dmafifo_adr), 64'(q[0][54:32]));
            check("head_data", 64'(ram_dmafifo_data), 64'(q[0][31:0]));
        end
    endtask

    // Applies one cycle of inputs, advances the model, then checks.
    task automatic step(input logic rst, input logic clr, input logic wr,
                        input logic [22:0] adr, input logic [31:0] dat,
                        input logic rd);
        logic was_full;
        logic was_empty;
        reset_n = rst;
        clear = clr;
        wr_en = wr;
        wr_adr = adr;
        wr_data = dat;
        ram_dmafifo_read = rd;
        @(posedge clk);
        if (!rst || clr) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && !was_full) q.push_back({adr[22:2], 2'b00, dat});
            if (wr && was_full) m_ovf = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic wr1(input logic [22:0] adr, input logic [31:0] dat);
        step(1'b1, 1'b0, 1'b1, adr, dat, 1'b0);
    endtask

    task automatic rd1();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("rst_adr", 64'(ram_dmafifo_adr), 64'h0);
        check("rst_data", 64'(ram_dmafifo_data), 64'h0);
        check("rst_count", 64'(count), 64'd0);

        wr1(23'h000104, 32'hDEADBEEF);
        check("first_adr", 64'(ram_dmafifo_adr), 64'h104);
        check("first_data", 64'(ram_dmafifo_data), 64'hDEADBEEF);
        check("first_count", 64'(count), 64'd1);
        rd1();
        check("pop_empty", 64'(ram_dmafifo_empty), 64'd1);

        wr1(23'h000107, 32'h12345678);
        check("align_adr", 64'(ram_dmafifo_adr), 64'h104);
        rd1();
        rd1();

        for (int i = 0; i < DEPTH; i++) begin
            wr1(23'($urandom), 32'(i));
            if (i == DEPTH - AF_MARGIN - 1)
                check("af_at_60", 64'(almost_full), 64'd1);
        end
        check("full_at_64", 64'(full), 64'd1);
        wr1(23'h7FFFFF, 32'hFFFFFFFF);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd64);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(ram_dmafifo_data), 64'(i));
            rd1();
        end

        for (int i = 0; i < DEPTH; i++) wr1(23'($urandom), 32'(i));
        step(1'b1, 1'b0, 1'b1, 23'h1, 32'hBAD, 1'b1);
        check("fullrw_count", 64'(count), 64'd63);
        check("fullrw_head", 64'(ram_dmafifo_data), 64'd1);
        while (q.size() != 0) rd1();

        step(1'b1, 1'b0, 1'b1, 23'h40, 32'hCAFE, 1'b1);
        check("emptyrw_count", 64'(count), 64'd1);
        check("emptyrw_empty", 64'(ram_dmafifo_empty), 64'd0);

        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b1, 23'($urandom), $urandom, 1'b1);
            if (i == 199) check("stream_count", 64'(count), 64'd1);
        end
        while (q.size() != 0) rd1();

        for (int i = 0; i < 5; i++) wr1(23'($urandom), $urandom);
        step(1'b1, 1'b1, 1'b1, 23'h55, 32'h55, 1'b0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_empty", 64'(ram_dmafifo_empty), 64'd1);
        check("clr_ovf", 64'(overflow), 64'd0);

        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), 23'($urandom), $urandom,
                 ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 40; i++) wr1(23'($urandom), $urandom);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b1, 23'($urandom), $urandom,
                 ($urandom_range(0, 1) == 1));
        step(1'b0, 1'b0, 1'b1, 23'h3, 32'h3, 1'b1);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_adr", 64'(ram_dmafifo_adr), 64'h0);
        check("midrst_data", 64'(ram_dmafifo_data), 64'h0);
        idle();
        wr1(23'h000200, 32'hA5A5A5A5);
        check("post_rst_head", 64'(ram_dmafifo_data), 64'hA5A5A5A5);
        rd1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
